sid_i2s_out: RTL

SID_I2S_OUT -- requirements
Module: sid_i2s_out

---
 rtl/sid_i2s_out_pkg.sv | 31 +++
 rtl/sid_i2s_out_if.sv | 40 ++++
 rtl/sid_i2s_out_decimator.sv | 55 +++++
 rtl/sid_i2s_out.sv | 103 ++++++++++
 4 files changed

// File: rtl/sid_i2s_out_pkg.sv
// Shared constants, types and slot helper for the SID I2S output path.
// Imported by the decimator, the bus interface and the serializer top.
package sid_i2s_out_pkg;

    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned FRAME_BITS = 64;
    localparam int unsigned SLOT_BITS  = 32;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    typedef struct packed {
        logic overrun;
        logic underrun;
    } flags_t;

    // One-bit I2S delay: slot s carries frame[16-s] for s in 1..16, else 0.
    function automatic logic slot_bit(input sample_t frame, input logic [4:0] s);
        logic [3:0] idx;
        slot_bit = 1'b0;
        idx      = 4'(int'(SAMPLE_W) - int'(s));
        if (s != 5'd0 && s <= 5'(SAMPLE_W)) begin
            slot_bit = frame[idx];
        end
    endfunction

endpackage

// File: rtl/sid_i2s_out_if.sv
// Sample input, flag control and I2S output bundle for sid_i2s_out.
// slave is the serializer side; master is the driving/observing side.
interface sid_i2s_out_if;
    import sid_i2s_out_pkg::*;

    logic [SAMPLE_W-1:0] iSample;
    logic                iSampleEn;
    logic                iClrFlags;
    logic                oBclk;
    logic                oLrclk;
    logic                oSdata;
    logic                oFrameStart;
    logic                oOverrun;
    logic                oUnderrun;

    modport master (
        output iSample,
        output iSampleEn,
        output iClrFlags,
        input  oBclk,
        input  oLrclk,
        input  oSdata,
        input  oFrameStart,
        input  oOverrun,
        input  oUnderrun
    );

    modport slave (
        input  iSample,
        input  iSampleEn,
        input  iClrFlags,
        output oBclk,
        output oLrclk,
        output oSdata,
        output oFrameStart,
        output oOverrun,
        output oUnderrun
    );

endinterface

// File: rtl/sid_i2s_out_decimator.sv
// Box-car decimator: sums 2^DECIM_LOG2 signed samples and holds the
// arithmetically shifted mean until the serializer consumes it.
module sid_decimator
    import sid_i2s_out_pkg::*;
#(
    parameter int unsigned DECIM_LOG2 = 5
) (
    input  logic                clk,
    input  logic                iRstN,
    input  logic [SAMPLE_W-1:0] iSample,
    input  logic                iSampleEn,
    input  logic                iConsume,
    output logic                oLoad,
    output logic [SAMPLE_W-1:0] oLoadVal,
    output logic [SAMPLE_W-1:0] oHold,
    output logic                oPending
);

    localparam int unsigned ACC_W = SAMPLE_W + DECIM_LOG2;

    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      acc_sum;
    logic        [DECIM_LOG2-1:0] cnt;

    always_comb begin
        acc_sum  = acc + $signed({{DECIM_LOG2{iSample[SAMPLE_W-1]}}, iSample});
        oLoad    = iSampleEn && (cnt == '1);
        oLoadVal = SAMPLE_W'(acc_sum >>> DECIM_LOG2);
    end

    always_ff @(posedge clk) begin
        if (!iRstN) begin
            acc      <= '0;
            cnt      <= '0;
            oHold    <= '0;
            oPending <= 1'b0;
        end else begin
            if (iSampleEn) begin
                cnt <= cnt + 1'b1;
                acc <= oLoad ? '0 : acc_sum;
            end
            if (oLoad) begin
                oHold <= oLoadVal;
            end
            // A load coinciding with consumption goes straight to the frame,
            // so nothing is left pending.
            if (oLoad && !iConsume) begin
                oPending <= 1'b1;
            end else if (iConsume) begin
                oPending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sid_i2s_out.sv
// Mono I2S transmitter for the SID mix: decimates the 1 MHz sample stream
// and shifts it MSB-first into both half-frames of a 64-bit I2S frame.
module sid_i2s_out
    import sid_i2s_out_pkg::*;
#(
    parameter int unsigned DECIM_LOG2 = 5,
    parameter int unsigned BCLK_DIV   = 6
) (
    input  logic         clk,
    input  logic         iRstN,
    sid_i2s_out_if.slave bus
);

    localparam int unsigned      DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [5:0]       BIT_LAST = 6'(FRAME_BITS - 1);
    localparam int unsigned      LR_BIT   = $clog2(SLOT_BITS);

    logic [DIV_W-1:0]    div;
    logic                bclk;
    logic [5:0]          bitcnt;
    logic [5:0]          bit_next;
    logic                sdata;
    sample_t             frame;
    logic                fs_q;
    flags_t              flags;
    chan_e               chan;

    logic                div_wrap;
    logic                bclk_fall;
    logic                frame_start;
    logic                set_ovr;
    logic                set_unr;

    logic                dec_load;
    logic                dec_pending;
    logic [SAMPLE_W-1:0] dec_val;
    logic [SAMPLE_W-1:0] dec_hold;

    sid_decimator #(
        .DECIM_LOG2(DECIM_LOG2)
    ) u_dec (
        .clk      (clk),
        .iRstN    (iRstN),
        .iSample  (bus.iSample),
        .iSampleEn(bus.iSampleEn),
        .iConsume (frame_start),
        .oLoad    (dec_load),
        .oLoadVal (dec_val),
        .oHold    (dec_hold),
        .oPending (dec_pending)
    );

    always_comb begin
        div_wrap    = (div == DIV_LAST);
        bclk_fall   = div_wrap && bclk;
        bit_next    = bitcnt + 6'd1;
        frame_start = bclk_fall && (bitcnt == BIT_LAST);
        set_ovr     = dec_load && dec_pending && !frame_start;
        set_unr     = frame_start && !dec_pending && !dec_load;
        chan        = chan_e'(bitcnt[LR_BIT]);
    end

    always_ff @(posedge clk) begin
        if (!iRstN) begin
            div    <= '0;
            bclk   <= 1'b0;
            bitcnt <= '0;
            sdata  <= 1'b0;
            frame  <= '0;
            fs_q   <= 1'b0;
            flags  <= '0;
        end else begin
            div <= div_wrap ? '0 : div + 1'b1;
            if (div_wrap) begin
                bclk <= ~bclk;
            end
            // Slot 0 of the new frame is always 0, so the old frame is safe here.
            if (bclk_fall) begin
                bitcnt <= bit_next;
                sdata  <= slot_bit(frame, bit_next[4:0]);
            end
            if (frame_start) begin
                if (dec_load) begin
                    frame <= dec_val;
                end else if (dec_pending) begin
                    frame <= dec_hold;
                end
            end
            fs_q           <= frame_start;
            flags.overrun  <= set_ovr | (flags.overrun  & ~bus.iClrFlags);
            flags.underrun <= set_unr | (flags.underrun & ~bus.iClrFlags);
        end
    end

    assign bus.oBclk       = bclk;
    assign bus.oLrclk      = (chan == CH_RIGHT);
    assign bus.oSdata      = sdata;
    assign bus.oFrameStart = fs_q;
    assign bus.oOverrun    = flags.overrun;
    assign bus.oUnderrun   = flags.underrun;

endmodule
